// File: rtl/forwarding_unit_pkg.sv
// forwarding_unit_pkg: shared widths, slot indices, tag type and RET reset constants for the decode bypass.
package forwarding_unit_pkg;
  localparam int DW = 16;
  localparam int RW = 3;
  localparam int SLOT_EX  = 0;
  localparam int SLOT_MEM = 1;
  localparam int SLOT_WB  = 2;
  localparam logic [RW-1:0] RET_RD_RST   = '0;
  localparam logic [DW-1:0] RET_DATA_RST = '0;
  typedef struct packed {
    logic          v;
    logic [RW-1:0] rd;
    logic          is_load;
  } tag_t;
endpackage

// File: rtl/forwarding_unit_tag_stage.sv
// forwarding_unit_tag_stage: one pipeline tag register {v, rd, is_load} with enable and async active-low clear.
module forwarding_unit_tag_stage
  import forwarding_unit_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  tag_t tag_d,
  output tag_t tag_q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) tag_q <= '0;
    else if (en) tag_q <= tag_d;
endmodule

// File: rtl/forwarding_unit.sv
// forwarding_unit: tracks EX/MEM/WB destination tags plus a retired-write slot and presents a
// (reg, data) pair per slot to decode, falling back to the next older valid slot; also raises load-use stall.
module forwarding_unit
  import forwarding_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            advance,
  input  logic            flush,
  input  logic            id_rd_valid,
  input  logic [RW-1:0]   id_rd_sel,
  input  logic            id_is_load,
  input  logic [RW-1:0]   id_rs_sel,
  input  logic [RW-1:0]   id_rt_sel,
  input  logic            id_rs_used,
  input  logic            id_rt_used,
  input  logic [DW-1:0]   ex_result,
  input  logic [DW-1:0]   mem_result,
  input  logic [DW-1:0]   wb_result,
  output logic [3*RW-1:0] Forwarding_vector,
  output logic [3*DW-1:0] Forwarding_data,
  output logic [2:0]      fwd_valid,
  output logic            load_use_stall
);
  tag_t ex_q, mem_q, wb_q, ex_d;
  logic [RW-1:0] ret_rd_q;
  logic [DW-1:0] ret_data_q;
  logic [RW-1:0] ex_rd, mem_rd, wb_rd;
  logic [DW-1:0] ex_dat, mem_dat, wb_dat;
  assign load_use_stall = ex_q.v & ex_q.is_load &
    ((id_rs_used & (id_rs_sel == ex_q.rd)) | (id_rt_used & (id_rt_sel == ex_q.rd)));
  assign ex_d = (id_rd_valid & ~flush & ~load_use_stall) ? '{v: 1'b1, rd: id_rd_sel, is_load: id_is_load} : '0;
  forwarding_unit_tag_stage u_ex  (.clk(clk), .rst(rst), .en(advance), .tag_d(ex_d),  .tag_q(ex_q));
  forwarding_unit_tag_stage u_mem (.clk(clk), .rst(rst), .en(advance), .tag_d(ex_q),  .tag_q(mem_q));
  forwarding_unit_tag_stage u_wb  (.clk(clk), .rst(rst), .en(advance), .tag_d(mem_q), .tag_q(wb_q));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ret_rd_q   <= RET_RD_RST;
      ret_data_q <= RET_DATA_RST;
    end else if (advance && wb_q.v) begin
      ret_rd_q   <= wb_q.rd;
      ret_data_q <= wb_result;
    end
  // Invalid slots copy the next older slot so a reg-only match never picks stale data.
  always_comb begin
    wb_rd   = wb_q.v  ? wb_q.rd    : ret_rd_q;
    wb_dat  = wb_q.v  ? wb_result  : ret_data_q;
    mem_rd  = mem_q.v ? mem_q.rd   : wb_rd;
    mem_dat = mem_q.v ? mem_result : wb_dat;
    ex_rd   = ex_q.v  ? ex_q.rd    : mem_rd;
    ex_dat  = ex_q.v  ? ex_result  : mem_dat;
  end
  assign Forwarding_vector = {wb_rd, mem_rd, ex_rd};
  assign Forwarding_data   = {wb_dat, mem_dat, ex_dat};
  assign fwd_valid         = {wb_q.v, mem_q.v, ex_q.v};
endmodule

// File: tb/tb_forwarding_unit.sv
// tb_forwarding_unit: directed scenarios plus randomized traffic checked against a list-search reference model.
module tb_forwarding_unit;
  logic clk = 0, rst = 0, advance = 0, flush = 0;
  logic id_rd_valid = 0, id_is_load = 0, id_rs_used = 0, id_rt_used = 0;
  logic [2:0] id_rd_sel = 0, id_rs_sel = 0, id_rt_sel = 0;
  logic [15:0] ex_result = 0, mem_result = 0, wb_result = 0;
  logic [8:0] Forwarding_vector;
  logic [47:0] Forwarding_data;
  logic [2:0] fwd_valid;
  logic load_use_stall;
  int n_chk = 0, n_pass = 0;
  bit mv[3], ml[3];
  logic [2:0] mr[3], ret_r;
  logic [15:0] ret_d;
  forwarding_unit dut (
    .clk(clk), .rst(rst), .advance(advance), .flush(flush),
    .id_rd_valid(id_rd_valid), .id_rd_sel(id_rd_sel), .id_is_load(id_is_load),
    .id_rs_sel(id_rs_sel), .id_rt_sel(id_rt_sel), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .ex_result(ex_result), .mem_result(mem_result), .wb_result(wb_result),
    .Forwarding_vector(Forwarding_vector), .Forwarding_data(Forwarding_data),
    .fwd_valid(fwd_valid), .load_use_stall(load_use_stall)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask
  task automatic idle();
    id_rd_valid = 0; id_is_load = 0; id_rs_used = 0; id_rt_used = 0; flush = 0;
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_vec"}, 64'(Forwarding_vector), 64'h0);
    check({tag, "_data"}, 64'(Forwarding_data), 64'h0);
    check({tag, "_vld"}, 64'(fwd_valid), 64'h0);
    check({tag, "_stall"}, 64'(load_use_stall), 64'h0);
  endtask
  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin mv[i] = 0; ml[i] = 0; mr[i] = 0; end
    ret_r = 0; ret_d = 0;
  endtask
  // One random cycle: inputs already driven; compare, then advance the model across the edge.
  task automatic model_cycle();
    logic [15:0] res[3];
    logic [2:0] er[3];
    logic [15:0] ed[3];
    bit stall;
    res[0] = ex_result; res[1] = mem_result; res[2] = wb_result;
    stall = mv[0] && ml[0] && ((id_rs_used && id_rs_sel == mr[0]) || (id_rt_used && id_rt_sel == mr[0]));
    for (int i = 0; i < 3; i++) begin
      er[i] = ret_r; ed[i] = ret_d;
      for (int j = 2; j >= i; j--) if (mv[j]) begin er[i] = mr[j]; ed[i] = res[j]; end
    end
    check("rnd_stall", 64'(load_use_stall), 64'(stall));
    check("rnd_vec", 64'(Forwarding_vector), 64'({er[2], er[1], er[0]}));
    check("rnd_data", 64'(Forwarding_data), 64'({ed[2], ed[1], ed[0]}));
    check("rnd_vld", 64'(fwd_valid), 64'({mv[2], mv[1], mv[0]}));
    @(posedge clk);
    if (advance) begin
      if (mv[2]) begin ret_r = mr[2]; ret_d = wb_result; end
      for (int i = 2; i > 0; i--) begin mv[i] = mv[i-1]; mr[i] = mr[i-1]; ml[i] = ml[i-1]; end
      mv[0] = id_rd_valid && !flush && !stall;
      mr[0] = mv[0] ? id_rd_sel : 3'd0;
      ml[0] = mv[0] && id_is_load;
    end
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("rst");
    rst = 1;
    tick();
    check_reset_outputs("post_rst");
    // ADD r3 flows to RET
    advance = 1; id_rd_valid = 1; id_rd_sel = 3;
    ex_result = 16'h0042; mem_result = 16'hAAAA; wb_result = 16'hBBBB;
    tick();
    idle();
    check("add_vec", 64'(Forwarding_vector), 64'({3'd0, 3'd0, 3'd3}));
    check("add_data", 64'(Forwarding_data), 64'({16'h0, 16'h0, 16'h0042}));
    mem_result = 16'h0042; wb_result = 16'h0042;
    repeat (3) tick();
    ex_result = 16'h1234; mem_result = 16'h5678; wb_result = 16'h9ABC;
    #1;
    check("ret_vec", 64'(Forwarding_vector), 64'({3'd3, 3'd3, 3'd3}));
    check("ret_data", 64'(Forwarding_data), 64'({3{16'h0042}}));
    check("ret_vld", 64'(fwd_valid), 64'h0);
    // Load-use
    id_rd_valid = 1; id_rd_sel = 2; id_is_load = 1;
    tick();
    id_is_load = 0; id_rd_sel = 4; id_rs_sel = 2; id_rs_used = 1;
    #1 check("lu_stall", 64'(load_use_stall), 64'h1);
    tick();
    check("lu_stall_gone", 64'(load_use_stall), 64'h0);
    check("lu_vld", 64'(fwd_valid), 64'b010);
    check("lu_vec", 64'(Forwarding_vector[5:0]), 64'({3'd2, 3'd2}));
    check("lu_data", 64'(Forwarding_data[31:0]), 64'({16'h5678, 16'h5678}));
    // Flush
    id_rs_used = 0; id_rd_sel = 5; flush = 1;
    tick();
    check("flush_vld", 64'(fwd_valid), 64'b100);
    // Freeze holds
    advance = 0;
    tick();
    tick();
    check("freeze_vld", 64'(fwd_valid), 64'b100);
    idle();
    // Mid-flight async reset
    advance = 1; id_rd_valid = 1;
    repeat (3) tick();
    check("full_vld", 64'(fwd_valid), 64'b111);
    #2 rst = 0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk) rst = 1;
    model_clear();
    // Random phase
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 99) < 2) begin
        #2 rst = 0;
        model_clear();
        #1 check_reset_outputs("rnd_rst");
        @(negedge clk) rst = 1;
      end
      advance = $urandom_range(0, 9) < 8;
      flush = $urandom_range(0, 9) == 0;
      id_rd_valid = $urandom_range(0, 9) < 7;
      id_is_load = $urandom_range(0, 9) < 4;
      id_rd_sel = 3'($urandom); id_rs_sel = 3'($urandom); id_rt_sel = 3'($urandom);
      id_rs_used = 1'($urandom); id_rt_used = 1'($urandom);
      ex_result = 16'($urandom); mem_result = 16'($urandom); wb_result = 16'($urandom);
      #1 model_cycle();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
